// File: rtl/adc_serial_capture.sv
// ADC serial capture: synchronises the ADC serial interface into the clk domain,
// deserialises MSB-first words and buffers them in a small FWFT FIFO with a
// valid/ready output handshake.
module adc_serial_capture #(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LVL_W      = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  adc_clk,
  input  logic                  adc_frame,
  input  logic                  adc_sdata,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LVL_W-1:0]      fifo_level,
  output logic                  frame_err,
  output logic                  overflow,
  input  logic                  overflow_clr
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  // Synchroniser bit order: {adc_clk, adc_frame, adc_sdata}
  logic [2:0] sync1_q, sync2_q;
  logic       clk_prev_q;
  logic       clk_s, frame_s, sdata_s, rise;

  state_e                state_q, state_d;
  logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d, shifted;
  logic                  push;
  logic                  frame_err_q, frame_err_d;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]      level_q;
  logic                  overflow_q;
  logic                  full, rd_en, wr_en, drop;

  assign clk_s   = sync2_q[2];
  assign frame_s = sync2_q[1];
  assign sdata_s = sync2_q[0];
  assign rise    = clk_s & ~clk_prev_q;
  assign shifted = {shift_q[DATA_WIDTH-2:0], sdata_s};

  // Two-stage synchroniser for all three serial signals, plus adc_clk edge history
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      clk_prev_q <= 1'b0;
    end else begin
      sync1_q    <= {adc_clk, adc_frame, adc_sdata};
      sync2_q    <= sync1_q;
      clk_prev_q <= sync2_q[2];
    end
  end

  // Deserialiser state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Deserialiser next state: shift on adc_clk rises, push on the final bit
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    push        = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rise && frame_s) begin
          shift_d   = shifted;
          bit_cnt_d = CntW'(1);
          state_d   = StShift;
        end
      end
      StShift: begin
        // Frame dropping mid-word takes priority over any coincident rise
        if (!frame_s) begin
          frame_err_d = 1'b1;
          bit_cnt_d   = '0;
          state_d     = StIdle;
        end else if (rise) begin
          shift_d = shifted;
          if (bit_cnt_q == CntW'(DATA_WIDTH - 1)) begin
            push      = 1'b1;
            bit_cnt_d = '0;
            state_d   = StDone;
          end else begin
            bit_cnt_d = bit_cnt_q + CntW'(1);
          end
        end
      end
      StDone: begin
        // Surplus bits of a long frame are dropped silently
        if (!frame_s) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign full  = (level_q == LVL_W'(FIFO_DEPTH));
  assign rd_en = out_valid & out_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign wr_en = push & (~full | rd_en);
  assign drop  = push & full & ~rd_en;

  // FIFO storage and pointers
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= shifted;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (rd_en) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (wr_en && !rd_en)      level_q <= level_q + LVL_W'(1);
      else if (!wr_en && rd_en) level_q <= level_q - LVL_W'(1);
    end
  end

  // Sticky overflow; a new drop beats a coincident clear
  always_ff @(posedge clk) begin
    if (reset)             overflow_q <= 1'b0;
    else if (drop)         overflow_q <= 1'b1;
    else if (overflow_clr) overflow_q <= 1'b0;
  end

  assign out_valid  = (level_q != '0);
  assign out_data   = mem_q[rd_ptr_q];
  assign fifo_level = level_q;
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_adc_serial_capture.sv
// Directed bench for adc_serial_capture: table of single-frame vectors plus
// hand-written overflow, full push/pop and reset-mid-word sequences.
module tb_adc_serial_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic        adc_clk, adc_frame, adc_sdata;
  logic [11:0] out_data;
  logic        out_valid, out_ready;
  logic [2:0]  fifo_level;
  logic        frame_err, overflow, overflow_clr;

  int n_vec  = 0;
  int n_miss = 0;

  adc_serial_capture #(
    .DATA_WIDTH(12),
    .FIFO_DEPTH(4),
    .LVL_W     (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .adc_clk     (adc_clk),
    .adc_frame   (adc_frame),
    .adc_sdata   (adc_sdata),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .fifo_level  (fifo_level),
    .frame_err   (frame_err),
    .overflow    (overflow),
    .overflow_clr(overflow_clr)
  );

  always #5 clk = ~clk;

  // Monitor on the falling edge: records every accepted word and frame_err activity
  logic [11:0] popped[$];
  int          err_pulses = 0;
  int          err_cycles = 0;
  logic        err_prev   = 1'b0;

  always @(negedge clk) begin
    if (out_valid && out_ready) popped.push_back(out_data);
    if (frame_err) begin
      err_cycles = err_cycles + 1;
      if (!err_prev) err_pulses = err_pulses + 1;
    end
    err_prev = frame_err;
  end

  typedef struct {
    logic [11:0] word;
    int          nbits;
    int          exp_pops;
    logic [11:0] exp_data;
    int          exp_errs;
  } vec_t;

  vec_t vecs[6];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    adc_sdata = b;
    adc_clk   = 1'b0;
    tick(3);
    adc_clk = 1'b1;
    tick(3);
  endtask

  // Bits past position 11 are sent as ones (long-frame tail)
  task automatic send_word(input logic [11:0] w, input int nbits);
    adc_frame = 1'b1;
    for (int i = 0; i < nbits; i++) send_bit((i < 12) ? w[11-i] : 1'b1);
    adc_clk = 1'b0;
    tick(3);
    adc_frame = 1'b0;
    tick(4);
  endtask

  initial begin
    int          qb, eb, cb;
    logic [11:0] w;

    vecs[0] = '{word: 12'hA5C, nbits: 12, exp_pops: 1, exp_data: 12'hA5C, exp_errs: 0};
    vecs[1] = '{word: 12'hB00, nbits: 5,  exp_pops: 0, exp_data: 12'h000, exp_errs: 1};
    vecs[2] = '{word: 12'h123, nbits: 12, exp_pops: 1, exp_data: 12'h123, exp_errs: 0};
    vecs[3] = '{word: 12'hFFF, nbits: 16, exp_pops: 1, exp_data: 12'hFFF, exp_errs: 0};
    vecs[4] = '{word: 12'h555, nbits: 12, exp_pops: 1, exp_data: 12'h555, exp_errs: 0};
    vecs[5] = '{word: 12'h000, nbits: 12, exp_pops: 1, exp_data: 12'h000, exp_errs: 0};

    reset        = 1'b1;
    adc_clk      = 1'b0;
    adc_frame    = 1'b0;
    adc_sdata    = 1'b0;
    out_ready    = 1'b0;
    overflow_clr = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(2);

    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_data", 32'(out_data), 32'd0);
    check("reset fifo_level", 32'(fifo_level), 32'd0);
    check("reset frame_err", 32'(frame_err), 32'd0);
    check("reset overflow", 32'(overflow), 32'd0);

    // Table-driven single frames with the consumer always ready
    out_ready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      qb = popped.size();
      eb = err_pulses;
      cb = err_cycles;
      send_word(vecs[v].word, vecs[v].nbits);
      tick(6);
      check($sformatf("vec%0d pops", v), 32'(popped.size() - qb), 32'(vecs[v].exp_pops));
      if (vecs[v].exp_pops > 0 && popped.size() > qb)
        check($sformatf("vec%0d data", v), 32'(popped[qb]), 32'(vecs[v].exp_data));
      check($sformatf("vec%0d err pulses", v), 32'(err_pulses - eb), 32'(vecs[v].exp_errs));
      check($sformatf("vec%0d err cycles", v), 32'(err_cycles - cb), 32'(vecs[v].exp_errs));
      check($sformatf("vec%0d level", v), 32'(fifo_level), 32'd0);
    end

    // Overflow: fifth word dropped while the consumer stalls
    out_ready = 1'b0;
    qb = popped.size();
    for (int k = 1; k <= 5; k++) send_word(12'(k), 12);
    check("ovf level", 32'(fifo_level), 32'd4);
    check("ovf flag", 32'(overflow), 32'd1);
    check("ovf head", 32'(out_data), 32'h001);
    out_ready = 1'b1;
    tick(8);
    check("ovf pops", 32'(popped.size() - qb), 32'd4);
    for (int k = 0; k < 4; k++)
      if (popped.size() > qb + k)
        check($sformatf("ovf data%0d", k), 32'(popped[qb+k]), 32'(k + 1));
    check("ovf level drained", 32'(fifo_level), 32'd0);
    check("ovf sticky", 32'(overflow), 32'd1);
    overflow_clr = 1'b1;
    tick(1);
    overflow_clr = 1'b0;
    check("ovf cleared", 32'(overflow), 32'd0);

    // Full FIFO: final push of 0x0FF coincides with a pop
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) send_word(12'h010 + 12'(k), 12);
    check("pp level pre", 32'(fifo_level), 32'd4);
    qb = popped.size();
    w  = 12'h0FF;
    adc_frame = 1'b1;
    for (int i = 0; i < 11; i++) send_bit(w[11-i]);
    adc_sdata = w[0];
    adc_clk   = 1'b0;
    tick(3);
    adc_clk = 1'b1;
    tick(2);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    check("pp level", 32'(fifo_level), 32'd4);
    check("pp overflow", 32'(overflow), 32'd0);
    check("pp one pop", 32'(popped.size() - qb), 32'd1);
    if (popped.size() > qb) check("pp pop data", 32'(popped[qb]), 32'h010);
    adc_clk = 1'b0;
    tick(3);
    adc_frame = 1'b0;
    tick(4);
    out_ready = 1'b1;
    tick(8);
    check("pp pops", 32'(popped.size() - qb), 32'd5);
    if (popped.size() >= qb + 5) begin
      check("pp data1", 32'(popped[qb+1]), 32'h011);
      check("pp data2", 32'(popped[qb+2]), 32'h012);
      check("pp data3", 32'(popped[qb+3]), 32'h013);
      check("pp last", 32'(popped[qb+4]), 32'h0FF);
    end
    check("pp level drained", 32'(fifo_level), 32'd0);

    // Reset mid-word: partial word vanishes without a frame error
    qb = popped.size();
    eb = err_pulses;
    adc_frame = 1'b1;
    for (int i = 0; i < 6; i++) send_bit(1'b1);
    adc_clk   = 1'b0;
    adc_frame = 1'b0;
    reset     = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(4);
    send_word(12'h800, 12);
    tick(6);
    check("rst pops", 32'(popped.size() - qb), 32'd1);
    if (popped.size() > qb) check("rst data", 32'(popped[qb]), 32'h800);
    check("rst no err", 32'(err_pulses - eb), 32'd0);
    check("rst level", 32'(fifo_level), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/adc_serial_capture.md
Name: adc_serial_capture

Overview:
- Receive-side companion to the ADC divided-clock generator. Samples the ADC serial interface (adc_clk, adc_frame, adc_sdata) in the system clock domain.
- Deserialises MSB-first words of DATA_WIDTH bits and buffers them in a small first-word-fall-through (FWFT) FIFO.
- Presents words to the downstream processing chain over a valid/ready handshake.

Parameters:
- DATA_WIDTH, 12, bits per ADC sample word (2..16).
- FIFO_DEPTH, 4, word buffer depth; power of two, ≥2.
- LVL_W, 3, width of fifo_level; must equal log2(FIFO_DEPTH)+1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- adc_clk  input  1  divided ADC serial clock; treated as data and synchronised internally.
- adc_frame  input  1  frame enable; high while a word is being shifted.
- adc_sdata  input  1  serial data, valid at adc_clk rising edge.
- out_data  output  DATA_WIDTH  head-of-FIFO word.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts out_data when out_valid && out_ready.
- fifo_level  output  LVL_W  number of words stored (0..FIFO_DEPTH).
- frame_err  output  1  one-cycle pulse on a short frame.
- overflow  output  1  sticky flag; a word was dropped because the FIFO was full.
- overflow_clr  input  1  clears overflow.

Behaviour:
- Reset, synchronous and active-high; at the clk edge with reset high, all of the following take effect:
  - synchronisers, shift register, bit counter and FIFO pointers go to 0; state goes to IDLE.
  - out_valid=0, out_data=0, fifo_level=0, frame_err=0, overflow=0.
  - reset mid-word discards the partial word; no frame_err is raised.
- Synchronisation:
  - adc_clk, adc_frame and adc_sdata each pass through a 2-FF synchroniser, all in the same stages so the three stay aligned.
  - A registered copy of the synchronised adc_clk gives edge detection: rise = sync & ~prev.
- Latency: a final bit whose adc_clk rise is stable before clk edge N is written at edge N+2. out_valid is high after edge N+2 when the FIFO was empty. There is no bypass path.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - rise with frame high → shift in the bit, bit_cnt=1, go to SHIFT.
  - rise with frame low → ignored.
- SHIFT:
  - rise → shift in the bit (MSB first), bit_cnt+1.
  - On the rise that captures bit DATA_WIDTH, push {shift[DATA_WIDTH-2:0], bit} in that same cycle and go to DONE.
  - frame low (synchronised) before completion → frame_err=1 for exactly one cycle, bit_cnt=0, go to IDLE, no push.
- DONE:
  - further rises are ignored; extra bits are discarded without error.
  - frame low → IDLE.
- Back-to-back frames: frame must go low for at least 1 synchronised cycle between words; a frame that stays high produces only one word.
- FIFO:
  - FWFT; out_data is driven from the head registers.
  - Pop when out_valid && out_ready.
  - Push when full with no pop in the same cycle → word dropped, overflow set.
  - Push and pop in the same cycle when full → both succeed; level is unchanged and overflow is not set.
  - Push and pop in the same cycle when empty → push only; no pop occurs since out_valid=0.
  - Pointers wrap modulo FIFO_DEPTH.
  - fifo_level updates in the same cycle as the push/pop.
- overflow:
  - overflow_clr clears overflow.
  - If overflow_clr and a new drop occur in the same cycle, the set wins.
- out_data holds its value while out_valid && !out_ready.

Test Plan:
- Single word: reset, then send 0xA5C MSB-first (12 adc_clk periods, frame high), out_ready=1 → one out_valid pulse with out_data=0xA5C; frame_err=0; fifo_level returns to 0.
- Short frame: 5 bits 10110, then frame drops → frame_err high for exactly 1 cycle; no push; fifo_level=0. Then a full word 0x123 → out_data=0x123.
- Overflow: out_ready=0, send 0x001..0x005 → fifo_level=4, overflow=1. Raise out_ready → reads 0x001, 0x002, 0x003, 0x004. Then pulse overflow_clr → overflow=0.
- Full with simultaneous push/pop: FIFO holding 4 words, out_ready=1 on the cycle the 5th word 0x0FF is pushed → fifo_level stays 4; overflow=0; 0x0FF is read last.
- Long frame: 16 rises with frame high, first 12 bits forming 0xFFF → exactly one word 0xFFF; no error.
- Reset mid-word: assert reset after 6 bits, then send 0x800 → only 0x800 emerges; frame_err never pulses.
